// File: rtl/servant_uart_loader.sv
// +----------------------------------------------------------------------------+
// | servant_uart_loader: UART (8N1) firmware receiver -> Wishbone RAM writer.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module servant_uart_loader #(
  parameter int unsigned CLKS_PER_BIT = 139,
  parameter int unsigned MEMSIZE      = 8192
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic        i_wb_ack,
  output logic        o_cpu_rst,
  output logic        o_done,
  output logic        o_err
);

  localparam int unsigned         c_word_limit = MEMSIZE / 4;
  localparam int unsigned         c_cw         = $clog2(c_word_limit + 1);
  localparam int unsigned         c_tw         = $clog2(CLKS_PER_BIT);
  localparam logic [c_tw-1:0]     c_half       = c_tw'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_tw-1:0]     c_full       = c_tw'(CLKS_PER_BIT - 1);
  localparam logic [31:0]         c_limit32    = 32'(c_word_limit);
  localparam logic [c_cw-1:0]     c_limit_cw   = c_cw'(c_word_limit);

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_WAIT  = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_DATA = 2'd1,
    ST_DONE = 2'd2
  } ld_state_t;

  // ---------------------------------------------------------------- UART RX
  logic            rx_meta_q, rx_sync_q;
  rx_state_t       rx_state_q;
  logic [c_tw-1:0] rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q;
  logic            rx_valid_q, rx_ferr_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= i_rx;
      rx_sync_q  <= rx_meta_q;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          // A line that is high again at mid-bit was only a glitch.
          if (rx_cnt_q == c_half) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + c_tw'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == c_full) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + c_tw'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == c_full) begin
            rx_cnt_q <= '0;
            if (rx_sync_q) begin
              rx_valid_q <= 1'b1;
              rx_state_q <= RX_IDLE;
            end else begin
              rx_ferr_q  <= 1'b1;
              rx_state_q <= RX_WAIT;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + c_tw'(1);
          end
        end
        RX_WAIT: begin
          if (rx_sync_q) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------ loader FSM
  ld_state_t       st_q;
  logic [1:0]      byte_cnt_q;
  logic [31:0]     word_q;
  logic [c_cw-1:0] count_q, widx_q;
  logic [31:0]     buf_q;
  logic            pend_q;
  logic            cyc_q, done_q, cpu_rst_q, err_q;
  logic [31:0]     adr_q, dat_q;

  logic [31:0]     w_word;
  logic            w_word_done;
  logic [c_cw-1:0] w_widx_inc;
  logic [31:0]     w_adr;

  assign w_word      = {rx_shift_q, word_q[31:8]};
  assign w_word_done = rx_valid_q && (byte_cnt_q == 2'd3);
  assign w_widx_inc  = widx_q + c_cw'(1);
  assign w_adr       = 32'({widx_q, 2'b00});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q       <= ST_HDR;
      byte_cnt_q <= '0;
      word_q     <= '0;
      count_q    <= '0;
      widx_q     <= '0;
      buf_q      <= '0;
      pend_q     <= 1'b0;
      cyc_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      done_q     <= 1'b0;
      cpu_rst_q  <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      if (rx_ferr_q && st_q != ST_DONE) err_q <= 1'b1;
      if (rx_valid_q && st_q != ST_DONE) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        word_q     <= w_word;
      end
      case (st_q)
        ST_HDR: begin
          if (w_word_done) begin
            if (w_word == 32'd0) begin
              st_q      <= ST_DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              st_q <= ST_DATA;
              if (w_word > c_limit32) begin
                err_q   <= 1'b1;
                count_q <= c_limit_cw;
              end else begin
                count_q <= w_word[c_cw-1:0];
              end
            end
          end
        end
        ST_DATA: begin
          if (cyc_q && i_wb_ack) begin
            cyc_q  <= 1'b0;
            widx_q <= w_widx_inc;
            if (w_widx_inc == count_q) begin
              st_q      <= ST_DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end
          end
          // A word accepted alongside an ack launches after the idle cycle.
          if (!cyc_q && pend_q) begin
            cyc_q  <= 1'b1;
            adr_q  <= w_adr;
            dat_q  <= buf_q;
            pend_q <= 1'b0;
          end
          if (w_word_done) begin
            if (!cyc_q && !pend_q) begin
              cyc_q <= 1'b1;
              adr_q <= w_adr;
              dat_q <= w_word;
            end else if (cyc_q && i_wb_ack) begin
              buf_q  <= w_word;
              pend_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          cyc_q <= 1'b0;
        end
        default: st_q <= ST_HDR;
      endcase
    end
  end

  assign o_wb_adr  = adr_q;
  assign o_wb_dat  = dat_q;
  assign o_wb_sel  = {4{cyc_q}};
  assign o_wb_we   = cyc_q;
  assign o_wb_cyc  = cyc_q;
  assign o_cpu_rst = cpu_rst_q;
  assign o_done    = done_q;
  assign o_err     = err_q;

endmodule

`default_nettype wire
